// File: rtl/store_split.sv
// Store beat generator: turns one store request into one or two word-aligned
// write beats with byte enables; word-crossing stores go low word first.
module store_split #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  output logic              busy,
  output logic              misaligned,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // Handshakes: a request transfers when req_valid && req_ready; a beat transfers
  // when mem_we && mem_ready, and until then mem_addr/mem_be/mem_wdata hold still.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         hi_wdata_q, hi_wdata_d;
  logic [3:0]          hi_be_q, hi_be_d;
  logic                busy_q, busy_d;
  logic                misaligned_q, misaligned_d;
  logic                done_q, done_d;

  logic                is_store;
  logic [3:0]          size_mask;
  logic [31:0]         data_masked;
  logic [1:0]          off;
  logic [7:0]          en_full;
  logic [63:0]         lane_data;
  logic [ADDR_W-1:0]   base;
  logic                accept;

  always_comb begin
    is_store    = 1'b1;
    size_mask   = 4'b0000;
    data_masked = 32'd0;
    case (opcode)
      5'd3, 5'd4, 5'd5: begin
        size_mask   = 4'b1111;
        data_masked = data;
      end
      5'd6, 5'd7, 5'd8: begin
        size_mask   = 4'b0011;
        data_masked = {16'd0, data[15:0]};
      end
      5'd9, 5'd10, 5'd11: begin
        size_mask   = 4'b0001;
        data_masked = {24'd0, data[7:0]};
      end
      default: is_store = 1'b0;
    endcase
    off       = addr[1:0];
    en_full   = {4'b0000, size_mask} << off;
    lane_data = {32'd0, data_masked} << {off, 3'b000};
    base      = {addr[ADDR_W-1:2], 2'b00};
  end

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    hi_wdata_d   = hi_wdata_q;
    hi_be_d      = hi_be_q;
    busy_d       = busy_q;
    misaligned_d = misaligned_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Non-store opcodes are consumed silently and leave no trace.
        if (accept && is_store) begin
          state_d      = S_BEAT0;
          mem_we_d     = 1'b1;
          mem_addr_d   = base;
          mem_be_d     = en_full[3:0];
          mem_wdata_d  = lane_data[31:0];
          hi_be_d      = en_full[7:4];
          hi_wdata_d   = lane_data[63:32];
          busy_d       = 1'b1;
          misaligned_d = (en_full[7:4] != 4'b0000);
        end
      end
      S_BEAT0: begin
        if (mem_ready) begin
          if (misaligned_q) begin
            state_d     = S_BEAT1;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_be_d    = hi_be_q;
            mem_wdata_d = hi_wdata_q;
          end else begin
            state_d      = S_IDLE;
            mem_we_d     = 1'b0;
            mem_addr_d   = '0;
            mem_be_d     = 4'b0000;
            mem_wdata_d  = 32'd0;
            busy_d       = 1'b0;
            misaligned_d = 1'b0;
            done_d       = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        if (mem_ready) begin
          state_d      = S_IDLE;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_be_d     = 4'b0000;
          mem_wdata_d  = 32'd0;
          busy_d       = 1'b0;
          misaligned_d = 1'b0;
          done_d       = 1'b1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        mem_we_d     = 1'b0;
        busy_d       = 1'b0;
        misaligned_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      mem_be_q     <= 4'b0000;
      hi_wdata_q   <= 32'd0;
      hi_be_q      <= 4'b0000;
      busy_q       <= 1'b0;
      misaligned_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      hi_wdata_q   <= hi_wdata_d;
      hi_be_q      <= hi_be_d;
      busy_q       <= busy_d;
      misaligned_q <= misaligned_d;
      done_q       <= done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign busy       = busy_q;
  assign misaligned = misaligned_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_store_split.sv
// Bench for store_split: a queue-of-beats model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_store_split;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [4:0]        opcode = 5'd0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       data = 32'd0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready = 1'b1;
  logic              busy;
  logic              misaligned;
  logic              done;
  logic [1:0]        state_dbg;

  store_split #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .addr       (addr),
    .data       (data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .misaligned (misaligned),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: beats still owed to memory, each packed {addr, be, wdata}
  logic [67:0] exp_q[$];
  logic        done_exp = 1'b0;
  logic        mis_exp  = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: beats a store must produce, straight from size/offset arithmetic
  function automatic int model_beats(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] d,
                                     output logic [67:0] b0, output logic [67:0] b1);
    int          sz;
    logic [63:0] m;
    logic [63:0] en;
    logic [63:0] dl;
    logic [31:0] base;
    b0 = '0;
    b1 = '0;
    if (op >= 5'd3 && op <= 5'd5)       sz = 4;
    else if (op >= 5'd6 && op <= 5'd8)  sz = 2;
    else if (op >= 5'd9 && op <= 5'd11) sz = 1;
    else                                sz = 0;
    if (sz == 0) return 0;
    m    = (64'd1 << (8 * sz)) - 64'd1;
    en   = ((64'd1 << sz) - 64'd1) << a[1:0];
    dl   = ({32'd0, d} & m) << (8 * a[1:0]);
    base = a & 32'hFFFF_FFFC;
    b0   = {base, en[3:0], dl[31:0]};
    if (en[7:4] == 4'd0) return 1;
    b1   = {base + 32'd4, en[7:4], dl[63:32]};
    return 2;
  endfunction

  // Compare process: advance the model on each edge, then check every output
  initial begin
    logic [67:0] b0, b1;
    int          n;
    forever begin
      @(posedge clk);
      #1;
      done_exp = 1'b0;
      if (!rst_n) begin
        exp_q.delete();
        mis_exp = 1'b0;
        chk("reset_fields", {4'd0, mem_addr, mem_be, mem_wdata}, 72'd0);
      end else if (exp_q.size() != 0) begin
        if (mem_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            done_exp = 1'b1;
            mis_exp  = 1'b0;
          end
        end
      end else if (req_valid) begin
        n = model_beats(opcode, addr, data, b0, b1);
        if (n > 0) exp_q.push_back(b0);
        if (n == 2) exp_q.push_back(b1);
        if (n > 0) mis_exp = (n == 2);
      end
      chk("mem_we", mem_we, exp_q.size() != 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("req_ready", req_ready, exp_q.size() == 0);
      chk("misaligned", misaligned, mis_exp);
      chk("done", done, done_exp);
      if (exp_q.size() != 0)
        chk("beat", {4'd0, mem_addr, mem_be, mem_wdata}, {4'd0, exp_q[0]});
    end
  end

  // Driver tasks
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
    opcode    = op;
    addr      = a;
    data      = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic chk_beat(input string name, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    chk(name, {3'd0, mem_we, mem_addr, mem_be, mem_wdata}, {3'd0, 1'b1, a, be, wd});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [67:0] b0, b1;
    int          n;

    // Pin the model against hand-computed beats
    n = model_beats(5'd3, 32'h0000_1001, 32'hAABB_CCDD, b0, b1);
    chk("model_w_n", n, 2);
    chk("model_w_b0", b0, {32'h0000_1000, 4'b1110, 32'hBBCC_DD00});
    chk("model_w_b1", b1, {32'h0000_1004, 4'b0001, 32'h0000_00AA});
    n = model_beats(5'd9, 32'h0000_3002, 32'hFFFF_FF5A, b0, b1);
    chk("model_b_n", n, 1);
    chk("model_b_b0", b0, {32'h0000_3000, 4'b0100, 32'h005A_0000});
    n = model_beats(5'd3, 32'hFFFF_FFFE, 32'h1122_3344, b0, b1);
    chk("model_wrap_b1", b1, {32'h0000_0000, 4'b0011, 32'h0000_1122});
    n = model_beats(5'd12, 32'h0000_0000, 32'h1, b0, b1);
    chk("model_nonstore_n", n, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_we", mem_we, 1'b0);
    chk("reset_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Split word store
    issue(5'd3, 32'h0000_1001, 32'hAABB_CCDD);
    chk_beat("s1_beat0", 32'h0000_1000, 4'b1110, 32'hBBCC_DD00);
    chk("s1_misaligned", misaligned, 1'b1);
    @(negedge clk);
    chk_beat("s1_beat1", 32'h0000_1004, 4'b0001, 32'h0000_00AA);
    @(negedge clk);
    chk("s1_done", done, 1'b1);
    chk("s1_we_off", mem_we, 1'b0);
    @(negedge clk);
    chk("s1_done_pulse", done, 1'b0);

    // Split halfword
    issue(5'd6, 32'h0000_2003, 32'hFFFF_1234);
    chk_beat("s2_beat0", 32'h0000_2000, 4'b1000, 32'h3400_0000);
    @(negedge clk);
    chk_beat("s2_beat1", 32'h0000_2004, 4'b0001, 32'h0000_0012);
    @(negedge clk);
    chk("s2_done", done, 1'b1);

    // Single byte
    issue(5'd9, 32'h0000_3002, 32'hFFFF_FF5A);
    chk_beat("s3_beat0", 32'h0000_3000, 4'b0100, 32'h005A_0000);
    chk("s3_misaligned", misaligned, 1'b0);
    @(negedge clk);
    chk("s3_done", done, 1'b1);

    // Address wrap
    issue(5'd3, 32'hFFFF_FFFE, 32'h1122_3344);
    chk_beat("s4_beat0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    @(negedge clk);
    chk_beat("s4_beat1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    @(negedge clk);
    chk("s4_done", done, 1'b1);

    // More aligned / in-word cases and non-stores, checked by the model
    issue(5'd5, 32'h0000_5008, 32'hCAFE_BABE);
    chk_beat("s5_word", 32'h0000_5008, 4'b1111, 32'hCAFE_BABE);
    repeat (2) @(negedge clk);
    issue(5'd8, 32'h0000_600A, 32'h1234_BEEF);
    chk_beat("s5_half_hi", 32'h0000_6008, 4'b1100, 32'hBEEF_0000);
    repeat (2) @(negedge clk);
    issue(5'd11, 32'h0000_700F, 32'h0000_0099);
    chk_beat("s5_byte_top", 32'h0000_700C, 4'b1000, 32'h9900_0000);
    repeat (2) @(negedge clk);
    issue(5'd12, 32'h0000_7000, 32'h1234_5678);
    chk("s5_nonstore_we", mem_we, 1'b0);
    issue(5'd2, 32'h0000_7004, 32'h1234_5678);
    chk("s5_nonstore2_we", mem_we, 1'b0);
    @(negedge clk);

    // Request held valid across a busy split store: re-accepted once idle
    opcode    = 5'd7;
    addr      = 32'h0000_8003;
    data      = 32'h0000_ABCD;
    req_valid = 1'b1;
    repeat (5) @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure on an aligned word
    mem_ready = 1'b0;
    issue(5'd3, 32'h0000_4000, 32'h0102_0304);
    for (int i = 0; i < 4; i++) begin
      chk_beat("bp_beat", 32'h0000_4000, 4'b1111, 32'h0102_0304);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_no_done", done, 1'b0);
      if (i < 3) @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", done, 1'b1);
    @(negedge clk);

    // Reset while beat 1 is pending
    issue(5'd3, 32'h0000_1001, 32'hAABB_CCDD);
    @(negedge clk);
    chk_beat("rst_pre_beat1", 32'h0000_1004, 4'b0001, 32'h0000_00AA);
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_after_done", done, 1'b0);
    chk("rst_after_we", mem_we, 1'b0);
    issue(5'd0, 32'h0000_9000, 32'h0000_0055);
    chk("rst_op0_we", mem_we, 1'b0);
    chk("rst_op0_busy", busy, 1'b0);
    @(negedge clk);
    chk("rst_op0_done", done, 1'b0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_split.md
Name: store_split

Overview:
- Store-side counterpart of the load writeback path.
- Takes one store request (opcode, byte address, register data) from the memory stage and turns it into word-aligned memory write beats with byte enables.
- Stores that cross a 32-bit word boundary are split into two beats: low word first, then high word. This matches the two-read merge used for misaligned loads.
- Sits between the memory stage and the data-memory write port. Holds the pipeline via busy while beats are outstanding.

Parameters:
- ADDR_W, 32, byte-address width. Word base = addr with bits [1:0] cleared; beat-1 address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- opcode  in  5  3..5 word, 6..8 halfword, 9..11 byte; any other value is a non-store
- addr  in  ADDR_W  byte address
- data  in  32  store data, right-justified
- mem_we  out  1  write beat valid
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_wdata  out  32  lane-positioned write data
- mem_be  out  4  byte enables; bit i = byte lane i (bits [8i+7:8i])
- mem_ready  in  1  memory accepts the current beat this cycle
- busy  out  1  state != IDLE; pipeline stall request
- misaligned  out  1  transaction in flight has two beats
- done  out  1  one-cycle pulse, the cycle after the final beat is accepted

Behaviour:
- Reset: when rst_n is low at posedge → state IDLE, and mem_we, busy, misaligned, done all 0. mem_addr, mem_wdata and mem_be are 0.
  - Reset mid-transaction abandons any unissued beat; no further writes occur.
- States: IDLE, BEAT0, BEAT1. All outputs are registered, except req_ready = (state == IDLE).
- Accept = req_valid && req_ready.
- Size decode:
  - size = 4 for opcode 3..5, 2 for 6..8, 1 for 9..11.
  - size mask m = 4'b1111 / 4'b0011 / 4'b0001.
  - off = addr[1:0].
- Data: masked to size (data & 0xFFFFFFFF / 0xFFFF / 0xFF) before shifting.
- Lane placement:
  - 8-bit enable E = m << off.
  - 64-bit lane data D = masked_data << (8*off).
  - Beat 0: addr = base, be = E[3:0], wdata = D[31:0].
  - Beat 1 (only if E[7:4] != 0): addr = base + 4 (wraps), be = E[7:4], wdata = D[63:32].
- Transitions:
  - IDLE, accept with store opcode → BEAT0. Capture request; mem_we = 1 and beat-0 fields valid on the next cycle; misaligned = (E[7:4] != 0).
  - IDLE, accept with non-store opcode → stay IDLE. No write and no done.
  - BEAT0 && mem_ready → BEAT1 if misaligned (beat-1 fields next cycle, mem_we stays 1). Otherwise → IDLE with mem_we = 0 and done = 1 for one cycle.
  - BEAT1 && mem_ready → IDLE with mem_we = 0 and done = 1 for one cycle.
  - Any beat with mem_ready low → hold; mem_addr, mem_wdata and mem_be stay bit-stable.
- Latency (with mem_ready always high):
  - aligned store: accept in cycle N, beat presented in N+1, done in N+2.
  - split store: beat 0 in N+1, beat 1 in N+2, done in N+3.
- misaligned is cleared on the return to IDLE.
- busy is 1 whenever the state is BEAT0 or BEAT1.

Test Plan:
- Word store, opcode 3, addr 0x1001, data 0xAABBCCDD → beat 0: addr 0x1000, be 1110, wdata 0xBBCCDD00. Beat 1: addr 0x1004, be 0001, wdata 0x000000AA. misaligned = 1; done in the third cycle after accept.
- Halfword, opcode 6, addr 0x2003, data 0xFFFF1234 → beat 0: addr 0x2000, be 1000, wdata 0x34000000. Beat 1: addr 0x2004, be 0001, wdata 0x00000012.
- Byte, opcode 9, addr 0x3002, data 0xFFFFFF5A → single beat: addr 0x3000, be 0100, wdata 0x005A0000. misaligned = 0; done two cycles after accept.
- Wrap: word at addr 0xFFFFFFFE, data 0x11223344 → beat 0: addr 0xFFFFFFFC, be 1100, wdata 0x33440000. Beat 1: addr 0x00000000, be 0011, wdata 0x00001122.
- Backpressure: aligned word at 0x4000 with mem_ready low for 3 cycles → mem_we, addr, be and wdata are stable for 4 cycles. Done follows the ready cycle; req_ready stays low throughout.
- Reset in BEAT1 of the first scenario → next cycle mem_we = 0, busy = 0, req_ready = 1. No beat 1 is issued and no done pulse occurs. A non-store opcode 0 request is then accepted with no write.
